spi_reg_bank: RTL and testbench
===============================

# spi_reg_bank

Parametrised SPI-slave register bank for the MCU-to-FPGA control bus: one SPI front end serving NUM_WR write registers and NUM_RD read ports of WIDTH bits each, selected by an address byte. It replaces the per-address single-register SPI instances with one decoder. It adds:
- readback of write registers;
- a coherent snapshot of read ports;
- frame-length checking that drops malformed frames;
- per-register write strobes.

## Interface
Parameters:
- WIDTH, 32: data bits per register (8..32).
- NUM_WR, 8: number of write registers.
- NUM_RD, 8: number of read ports.
- WR_BASE, 10: address of write register 0; register i at WR_BASE+i.
- RD_BASE, 19: address of read port 0; port j at RD_BASE+j.
- Address ranges must not overlap and must fit in 7 bits.

Ports:
- clk  in  1  system clock (20 MHz); all logic in this domain.
- rst  in  1  reset, asynchronous, active-high.
- sclk  in  1  SPI clock, mode 0, asynchronous to clk.
- cs_n  in  1  SPI chip select, active low.
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out; idle level 1 so several slaves can be AND-combined.
- rd_data  in  NUM_RD*WIDTH  read port values; port j occupies bits [j*WIDTH +: WIDTH].
- wr_data  out  NUM_WR*WIDTH  write register contents; same packing as rd_data.
- wr_stb  out  NUM_WR  one-clk pulse when register i is written.
- frame_err  out  16  saturating count of discarded frames.

## Operation
- sclk, cs_n and mosi pass through 2-FF synchronisers. Edges of sclk and cs_n are detected on the synchronised signals.
- Frame format: address byte first, then WIDTH data bits.
  - Address byte: bit7 = W (1 = write, 0 = read), bits6:0 = address.
- State machine states: IDLE, ADDR, DATA, HOLD.
  - IDLE -> ADDR on the synchronised cs_n falling edge. This clears the bit counter and the shift register.
  - In ADDR, mosi is sampled on each sclk rising edge. After the 8th bit, the address is decoded and the block goes to DATA.
  - Decoding at the 8th bit loads the transmit register:
    - read-port address: snapshot of rd_data[j];
    - write-register address (either W value): current wr_data[i];
    - unmapped address: all ones.
  - In DATA, mosi is shifted in and the transmit register is shifted out. After WIDTH bits the block goes to HOLD.
  - HOLD waits for cs_n to rise; further sclk rising edges mark the frame overlong.
  - A cs_n rising edge in any non-IDLE state returns to IDLE.
- Write commit happens only when all of these hold: cs_n rises in HOLD, the frame was not overlong, W = 1, and the address maps to a write register. Commit loads wr_data[i] from the shift register and pulses wr_stb[i].
- Errors: a cs_n rise in ADDR or DATA, or an overlong frame, increments frame_err (saturating at 16'hFFFF). No register changes on an error. A W = 1 frame to an unmapped or read-only address is silently ignored, with no error count.
- miso:
  - 1 in IDLE and ADDR;
  - in DATA, the transmit MSB, updated on each synchronised sclk falling edge;
  - 1 again in HOLD.
- Reset (asynchronous, any time, including mid-frame):
  - state IDLE;
  - wr_data all 0, wr_stb 0, frame_err 0, miso 1;
  - shift register and counter cleared.
  - After reset, the first frame is honoured only if cs_n has been seen high (synchronised) at least once.

## Timing
- sclk frequency is at most clk/8. Minimum sclk high/low time is 4 clk; minimum cs_n high time is 4 clk.
- mosi sampling: 2 clk after the sclk rising edge reaches the pin (synchroniser). Data is stable because the master changes mosi only on falling edges.
- miso update: it changes 3 clk after the sclk falling edge at the pin, well before the next rising edge at clk/8.
- Commit: wr_data and wr_stb change 3 clk after cs_n rises at the pin. wr_stb is high for exactly 1 clk.
- Read snapshot: taken in the clk cycle that processes the 8th rising edge. Later changes on rd_data do not affect the frame.
- Simultaneous events (same cycle): a cs_n rise takes priority over an sclk edge, which is ignored.

## Structure
- Package spi_reg_pkg:
  - state enum;
  - ADDR_BITS = 8;
  - localparam for the W bit position;
  - function addr_in_range(addr, base, num).
- Sub-module spi_edge_sync: 2-FF synchroniser plus rise/fall pulse outputs. One instance each for sclk and cs_n; mosi uses plain 2-FF.
- Top-level: FSM, bit counter ($clog2(WIDTH+9) bits), shift/transmit registers, register array, error counter.

## Test plan
- Write 32'hDEEDBEEF to address 10 (frame 0x8A then data) -> wr_data[0] = DEEDBEEF 3 clk after cs_n rise; wr_stb[0] pulses 1 clk; no other strobe.
- Read address 10 afterwards (0x0A) -> miso shifts DEEDBEEF MSB first; frame_err stays 0.
- rd_data[2] = 0x12345678 at the 8th rising edge, then changed to 0 during the data bits; read of address 21 -> 0x12345678 returned.
- Abort a write to address 11 after 20 data bits -> wr_data[1] unchanged, no wr_stb, frame_err = 1. A 41-bit frame (one extra bit) -> same outcome, frame_err = 2.
- Read unmapped address 0x7F -> all-ones data; write 0x93 (read port 0) -> ignored, no error.
- Assert rst mid-DATA of a write -> all outputs reach reset values asynchronously. The next full frame after cs_n has cycled high succeeds.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register bank.
// A frame is one command byte (W flag + 7-bit address) then WIDTH data bits.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_HOLD
  } state_t;

  localparam int ADDR_BITS = 8;
  localparam int W_BIT     = 7;

  function automatic logic addr_in_range(
    input logic [6:0] addr,
    input int         base,
    input int         num
  );
    return (int'(addr) >= base) && (int'(addr) < base + num);
  endfunction

endpackage

// File: rtl/spi_reg_bank_sync.sv
// 2-FF synchroniser with single-cycle rise/fall pulses.
// Resets low, so a line held low through reset never yields a false edge.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_sig;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave serving NUM_WR write registers and NUM_RD read ports.
// Malformed frames are dropped and counted; writes commit on cs_n release.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_WR  = 8,
  parameter int NUM_RD  = 8,
  parameter int WR_BASE = 10,
  parameter int RD_BASE = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  input  logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_WR*WIDTH-1:0] wr_data,
  output logic [NUM_WR-1:0]       wr_stb,
  output logic [15:0]             frame_err
);

  localparam int CW = $clog2(WIDTH + 9);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(ADDR_BITS + WIDTH - 1);

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  logic r_mosi_meta;
  logic r_mosi;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [WIDTH-1:0]        r_shift;
  logic [WIDTH-1:0]        r_tx;
  logic [ADDR_BITS-1:0]    r_cmd;
  logic                    r_over;
  logic                    r_miso;
  logic [NUM_WR*WIDTH-1:0] r_wr_data;
  logic [NUM_WR-1:0]       r_stb;
  logic [15:0]             r_err;

  logic [ADDR_BITS-1:0]    w_byte;
  logic [WIDTH-1:0]        w_tx_load;
  logic [15:0]             w_err_next;
  logic                    w_commit;

  spi_edge_sync u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_edge_sync u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (cs_n),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mosi_meta <= 1'b0;
      r_mosi      <= 1'b0;
    end else begin
      r_mosi_meta <= mosi;
      r_mosi      <= r_mosi_meta;
    end
  end

  // Command byte as it stands once the 8th bit arrives.
  always_comb begin
    w_byte    = {r_shift[ADDR_BITS-2:0], r_mosi};
    w_tx_load = '1;
    for (int i = 0; i < NUM_WR; i++) begin
      if (int'(w_byte[W_BIT-1:0]) == WR_BASE + i)
        w_tx_load = r_wr_data[i*WIDTH +: WIDTH];
    end
    for (int j = 0; j < NUM_RD; j++) begin
      if (int'(w_byte[W_BIT-1:0]) == RD_BASE + j)
        w_tx_load = rd_data[j*WIDTH +: WIDTH];
    end
  end

  assign w_err_next = (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
  assign w_commit   = r_cmd[W_BIT] &&
                      addr_in_range(r_cmd[W_BIT-1:0], WR_BASE, NUM_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
      r_cmd     <= '0;
      r_over    <= 1'b0;
      r_miso    <= 1'b1;
      r_wr_data <= '0;
      r_stb     <= '0;
      r_err     <= '0;
    end else begin
      r_stb <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state <= S_ADDR;
            r_cnt   <= '0;
            r_shift <= '0;
            r_over  <= 1'b0;
            r_miso  <= 1'b1;
          end
        end
        S_ADDR: begin
          if (w_cs_rise) begin
            r_state <= S_IDLE;
            r_err   <= w_err_next;
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[WIDTH-2:0], r_mosi};
            r_cnt   <= r_cnt + CW'(1);
            if (r_cnt == ADDR_LAST) begin
              r_cmd   <= w_byte;
              r_tx    <= w_tx_load;
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_cs_rise) begin
            r_state <= S_IDLE;
            r_err   <= w_err_next;
            r_miso  <= 1'b1;
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[WIDTH-2:0], r_mosi};
            r_cnt   <= r_cnt + CW'(1);
            if (r_cnt == DATA_LAST) begin
              r_state <= S_HOLD;
              r_miso  <= 1'b1;
            end
          end else if (w_sclk_fall) begin
            r_miso <= r_tx[WIDTH-1];
            r_tx   <= {r_tx[WIDTH-2:0], 1'b0};
          end
        end
        S_HOLD: begin
          if (w_cs_rise) begin
            r_state <= S_IDLE;
            if (r_over) begin
              r_err <= w_err_next;
            end else if (w_commit) begin
              for (int i = 0; i < NUM_WR; i++) begin
                if (int'(r_cmd[W_BIT-1:0]) == WR_BASE + i) begin
                  r_wr_data[i*WIDTH +: WIDTH] <= r_shift;
                  r_stb[i]                    <= 1'b1;
                end
              end
            end
          end else if (w_sclk_rise) begin
            r_over <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign miso      = r_miso;
  assign wr_data   = r_wr_data;
  assign wr_stb    = r_stb;
  assign frame_err = r_err;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: fixed vector table, hand sequences, random frames.
// Expected values come from constants and an address-map reference model.
module tb_spi_reg_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic [255:0] rd_data;
  logic [255:0] wr_data;
  logic [7:0]   wr_stb;
  logic [15:0]  frame_err;

  spi_reg_bank dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .rd_data   (rd_data),
    .wr_data   (wr_data),
    .wr_stb    (wr_stb),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_wr [8];
  logic [15:0] m_err;
  int          m_stb [8];

  int          stb_cnt [8];
  int          dbl = 0;
  logic [7:0]  stb_prev = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (wr_stb[i] === 1'b1) begin
        stb_cnt[i]++;
        if (stb_prev[i] === 1'b1) dbl++;
      end
    end
    stb_prev = wr_stb;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wr_of(input int i);
    return wr_data[i*32 +: 32];
  endfunction

  function automatic logic [31:0] model_rx(input logic [7:0] cmd);
    int a = int'(cmd[6:0]);
    if (a >= 10 && a < 18) return m_wr[a-10];
    if (a >= 19 && a < 27) return rd_data[(a-19)*32 +: 32];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model_apply(input logic [7:0] cmd, input logic [31:0] d,
                             input int nd);
    int a = int'(cmd[6:0]);
    if (nd != 32) begin
      if (m_err != 16'hFFFF) m_err++;
    end else if (cmd[7] && a >= 10 && a < 18) begin
      m_wr[a-10] = d;
      m_stb[a-10]++;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_err"}, 64'(frame_err), 64'(m_err));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_wr%0d", tag, i), 64'(wr_of(i)), 64'(m_wr[i]));
      check($sformatf("%s_stb%0d", tag, i), 64'(stb_cnt[i]), 64'(m_stb[i]));
    end
  endtask

  task automatic send_bit(input logic b, output logic m);
    mosi = b;
    repeat (5) @(negedge clk);
    sclk = 1'b1;
    m = miso;
    repeat (5) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] cmd);
    logic m;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) send_bit(cmd[7-i], m);
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [31:0] d,
                       input int nd, output logic [31:0] rx);
    logic m;
    logic b;
    rx = '0;
    send_cmd(cmd);
    for (int i = 0; i < nd; i++) begin
      b = (i < 32) ? d[31-i] : 1'b0;
      send_bit(b, m);
      if (i < 32) rx[31-i] = m;
    end
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] d;
    int          nd;
    logic        chk_rx;
    logic [31:0] rx;
    logic [15:0] err;
    logic [31:0] wr0;
    logic [31:0] wr1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rx;
    logic        m;
    logic [7:0]  cmd;
    logic [31:0] d;
    logic [31:0] exp_rx;
    int          nd;
    int          sel;

    rst = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    rd_data = '0;
    m_err = '0;
    for (int i = 0; i < 8; i++) begin
      m_wr[i] = '0;
      m_stb[i] = 0;
      stb_cnt[i] = 0;
      rd_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end

    vecs[0] = '{8'h8A, 32'hDEED_BEEF, 32, 1'b1, 32'h0,
                16'd0, 32'hDEED_BEEF, 32'h0};
    vecs[1] = '{8'h0A, 32'h0, 32, 1'b1, 32'hDEED_BEEF,
                16'd0, 32'hDEED_BEEF, 32'h0};
    vecs[2] = '{8'h7F, 32'h0, 32, 1'b1, 32'hFFFF_FFFF,
                16'd0, 32'hDEED_BEEF, 32'h0};
    vecs[3] = '{8'h93, 32'h0001_2345, 32, 1'b1, 32'hA000_0000,
                16'd0, 32'hDEED_BEEF, 32'h0};
    vecs[4] = '{8'h8B, 32'hCAFE_F00D, 20, 1'b0, 32'h0,
                16'd1, 32'hDEED_BEEF, 32'h0};
    vecs[5] = '{8'h8B, 32'h0BAD_F00D, 33, 1'b0, 32'h0,
                16'd2, 32'hDEED_BEEF, 32'h0};
    vecs[6] = '{8'h0B, 32'h0, 32, 1'b1, 32'h0,
                16'd2, 32'hDEED_BEEF, 32'h0};
    vecs[7] = '{8'h8B, 32'h0102_0304, 32, 1'b1, 32'h0,
                16'd2, 32'hDEED_BEEF, 32'h0102_0304};

    repeat (4) @(negedge clk);
    check("rst_wr", 64'(|wr_data), 64'd0);
    check("rst_stb", 64'(wr_stb), 64'd0);
    check("rst_err", 64'(frame_err), 64'd0);
    check("rst_miso", 64'(miso), 64'd1);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      frame(vecs[v].cmd, vecs[v].d, vecs[v].nd, rx);
      if (vecs[v].chk_rx)
        check($sformatf("vec%0d_rx", v), 64'(rx), 64'(vecs[v].rx));
      check($sformatf("vec%0d_err", v), 64'(frame_err), 64'(vecs[v].err));
      check($sformatf("vec%0d_wr0", v), 64'(wr_of(0)), 64'(vecs[v].wr0));
      check($sformatf("vec%0d_wr1", v), 64'(wr_of(1)), 64'(vecs[v].wr1));
      model_apply(vecs[v].cmd, vecs[v].d, vecs[v].nd);
      for (int i = 0; i < 8; i++)
        check($sformatf("vec%0d_stb%0d", v, i),
              64'(stb_cnt[i]), 64'(m_stb[i]));
    end

    // Commit latency: 3 clk after cs_n rises, strobe one clk wide.
    d = 32'h1122_3344;
    send_cmd(8'h8D);
    for (int i = 0; i < 32; i++) send_bit(d[31-i], m);
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("cmt_early_wr", 64'(wr_of(3)), 64'd0);
    check("cmt_early_stb", 64'(wr_stb), 64'd0);
    @(negedge clk);
    check("cmt_wr", 64'(wr_of(3)), 64'h1122_3344);
    check("cmt_stb", 64'(wr_stb), 64'h08);
    @(negedge clk);
    check("cmt_stb_off", 64'(wr_stb), 64'd0);
    model_apply(8'h8D, d, 32);
    repeat (6) @(negedge clk);
    check_model("cmt");

    // Read snapshot: port 2 changes after the command byte.
    rd_data[2*32 +: 32] = 32'h1234_5678;
    send_cmd(8'h15);
    rd_data[2*32 +: 32] = 32'h0;
    rx = '0;
    for (int i = 0; i < 32; i++) begin
      send_bit(1'b0, m);
      rx[31-i] = m;
    end
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("snap_rx", 64'(rx), 64'h1234_5678);
    check_model("snap");

    // Asynchronous reset in the middle of a write's data phase.
    send_cmd(8'h8C);
    for (int i = 0; i < 10; i++) send_bit(1'b0, m);
    repeat (4) @(negedge clk);
    check("pre_rst_miso", 64'(miso), 64'd0);
    #3 rst = 1'b1;
    #1;
    check("arst_wr", 64'(|wr_data), 64'd0);
    check("arst_stb", 64'(wr_stb), 64'd0);
    check("arst_err", 64'(frame_err), 64'd0);
    check("arst_miso", 64'(miso), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_err = '0;
    for (int i = 0; i < 8; i++) m_wr[i] = '0;
    for (int i = 0; i < 22; i++) send_bit(1'b1, m);
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check_model("post_rst");
    frame(8'h8C, 32'h5A5A_A5A5, 32, rx);
    check("post_rst_rx", 64'(rx), 64'd0);
    model_apply(8'h8C, 32'h5A5A_A5A5, 32);
    check_model("post_rst_wr");

    for (int k = 0; k < 24; k++) begin
      for (int j = 0; j < 8; j++) rd_data[j*32 +: 32] = $urandom;
      sel = int'($urandom_range(0, 3));
      d = $urandom;
      nd = 32;
      unique case (sel)
        0: cmd = {1'b1, 7'(10 + $urandom_range(0, 7))};
        1: cmd = {1'b0, 7'($urandom_range(10, 26))};
        2: cmd = 8'($urandom);
        default: begin
          cmd = {1'b1, 7'(10 + $urandom_range(0, 7))};
          nd = int'($urandom_range(0, 40));
        end
      endcase
      exp_rx = model_rx(cmd);
      frame(cmd, d, nd, rx);
      if (nd >= 32)
        check($sformatf("rnd%0d_rx_cmd%02h", k, cmd), 64'(rx), 64'(exp_rx));
      model_apply(cmd, d, nd);
      check_model($sformatf("rnd%0d", k));
    end

    check("stb_width", 64'(dbl), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
